// File: rtl/fpdiv_seq_arbiter.sv
// rtl/fpdiv_seq_arbiter.sv - two-port arbitrated sequential FP32 divider, one quotient bit per cycle
// Optional macro FPDIV_SEQ_ZERO_CHK_EN adds res_dz and a zero-divisor fast path.
module fpdiv_seq_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [31:0] res_data,
  output logic        res_overflow,
  output logic        res_underflow,
  output logic        busy
`ifdef FPDIV_SEQ_ZERO_CHK_EN
  ,output logic       res_dz
`endif
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q;
  logic        id_q;
  logic        sign_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [23:0] q_q;
  logic [4:0]  cnt_q;
  logic [31:0] data_q;
  logic        ovf_q, unf_q;
`ifdef FPDIV_SEQ_ZERO_CHK_EN
  logic        dz_q;
  logic        zero_div;
`endif

  logic        any_valid, pick1, accept;
  logic [31:0] sel_a, sel_b;
  logic [24:0] rem_sh, rem_nx;
  logic        ge;
  logic [8:0]  e_n;
  logic [22:0] mant_n;

  // Round-robin favours whoever was not granted last; last_q resets to 1 so req0 goes first.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid)
      pick1 = (FIXED_PRIO == 0) && !last_q;
    else
      pick1 = req1_valid;
    sel_a  = pick1 ? req1_a : req0_a;
    sel_b  = pick1 ? req1_b : req0_b;
    accept = (state_q == IDLE) && any_valid;
  end

`ifdef FPDIV_SEQ_ZERO_CHK_EN
  assign zero_div = (sel_b[30:0] == 31'd0);
`endif

  // First step compares the unshifted remainder; later steps shift in a zero first.
  always_comb begin
    rem_sh = (cnt_q == 5'd0) ? rem_q : {rem_q[23:0], 1'b0};
    ge     = (rem_sh >= {1'b0, mb_q});
    rem_nx = ge ? (rem_sh - {1'b0, mb_q}) : rem_sh;
  end

  always_comb begin
    e_n    = {1'b0, ea_q} + 9'd127 - {1'b0, eb_q} - {8'd0, ~q_q[23]};
    mant_n = q_q[23] ? q_q[22:0] : {q_q[21:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef FPDIV_SEQ_ZERO_CHK_EN
          state_d = zero_div ? DONE : DIVIDE;
`else
          state_d = DIVIDE;
`endif
        end
      end
      DIVIDE:  if (cnt_q == 5'd23) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Readies are gated by rst_n so every output is low while reset is held.
  always_comb begin
    req0_ready = rst_n && (state_q == IDLE) && any_valid && !pick1;
    req1_ready = rst_n && (state_q == IDLE) && any_valid && pick1;
    res_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      id_q   <= 1'b0;
      sign_q <= 1'b0;
      ea_q   <= 8'd0;
      eb_q   <= 8'd0;
      mb_q   <= 24'd0;
      rem_q  <= 25'd0;
      q_q    <= 24'd0;
      cnt_q  <= 5'd0;
      data_q <= 32'd0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
`ifdef FPDIV_SEQ_ZERO_CHK_EN
      dz_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            id_q   <= pick1;
            sign_q <= sel_a[31] ^ sel_b[31];
            ea_q   <= sel_a[30:23];
            eb_q   <= sel_b[30:23];
            mb_q   <= {1'b1, sel_b[22:0]};
            rem_q  <= {2'b01, sel_a[22:0]};
            q_q    <= 24'd0;
            cnt_q  <= 5'd0;
`ifdef FPDIV_SEQ_ZERO_CHK_EN
            if (zero_div) begin
              data_q <= {sel_a[31] ^ sel_b[31], 8'hFF, 23'd0};
              ovf_q  <= 1'b1;
              unf_q  <= 1'b0;
              dz_q   <= 1'b1;
            end
`endif
          end
        end
        DIVIDE: begin
          rem_q <= rem_nx;
          q_q   <= {q_q[22:0], ge};
          cnt_q <= cnt_q + 5'd1;
        end
        NORM: begin
`ifdef FPDIV_SEQ_ZERO_CHK_EN
          dz_q <= 1'b0;
`endif
          if (e_n == 9'd255 || e_n[8:7] == 2'b10) begin
            data_q <= 32'd0;
            ovf_q  <= 1'b1;
            unf_q  <= 1'b0;
          end else if (e_n[8:7] == 2'b11) begin
            data_q <= 32'd0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b1;
          end else begin
            data_q <= {sign_q, e_n[7:0], mant_n};
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
          end
        end
        DONE: begin
          if (res_ready) last_q <= id_q;
        end
        default: ;
      endcase
    end
  end

  assign res_id        = id_q;
  assign res_data      = data_q;
  assign res_overflow  = ovf_q;
  assign res_underflow = unf_q;
`ifdef FPDIV_SEQ_ZERO_CHK_EN
  assign res_dz        = dz_q;
`endif

endmodule

// File: tb/tb_fpdiv_seq_arbiter.sv
// tb/tb_fpdiv_seq_arbiter.sv - directed self-checking bench for fpdiv_seq_arbiter
module tb_fpdiv_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_id, res_overflow, res_underflow, busy;
  logic [31:0] res_data;
  logic        res_dz;

  logic        f_v0, f_v1, f_r0, f_r1, f_res_valid, f_res_ready, f_res_id;
  logic        f_ovf, f_unf, f_busy, f_dz;
  logic [31:0] f_res_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpdiv_seq_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data),
    .res_overflow(res_overflow), .res_underflow(res_underflow), .busy(busy)
`ifdef FPDIV_SEQ_ZERO_CHK_EN
    , .res_dz(res_dz)
`endif
  );

  fpdiv_seq_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_v0), .req0_a(32'h40C00000), .req0_b(32'h40000000), .req0_ready(f_r0),
    .req1_valid(f_v1), .req1_a(32'hC0C00000), .req1_b(32'h40000000), .req1_ready(f_r1),
    .res_valid(f_res_valid), .res_ready(f_res_ready), .res_id(f_res_id), .res_data(f_res_data),
    .res_overflow(f_ovf), .res_underflow(f_unf), .busy(f_busy)
`ifdef FPDIV_SEQ_ZERO_CHK_EN
    , .res_dz(f_dz)
`endif
  );

`ifndef FPDIV_SEQ_ZERO_CHK_EN
  assign res_dz = 1'b0;
  assign f_dz   = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic v0, input logic v1,
                    input logic [31:0] a0, input logic [31:0] b0,
                    input logic [31:0] a1, input logic [31:0] b1,
                    input logic exp_id, input logic [31:0] exp_data,
                    input logic exp_ovf, input logic exp_unf, input logic exp_dz,
                    input int lat, input int hold);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    chk("ready0", req0_ready, (exp_id == 1'b0));
    chk("ready1", req1_ready, (exp_id == 1'b1));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEADBEEF; req1_a = 32'hDEADBEEF;
    if (lat > 1) begin
      repeat (lat - 1) @(posedge clk);
      #1;
      chk("early_valid", res_valid, 1'b0);
      chk("busy_run", busy, 1'b1);
      @(posedge clk); #1;
    end
    chk("res_valid", res_valid, 1'b1);
    chk("res_data", res_data, exp_data);
    chk("res_id", res_id, exp_id);
    chk("res_ovf", res_overflow, exp_ovf);
    chk("res_unf", res_underflow, exp_unf);
    chk("res_dz", res_dz, exp_dz);
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_data", res_data, exp_data);
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_rdy0", req0_ready, 1'b0);
      chk("hold_rdy1", req1_ready, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post_valid", res_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    f_v0 = 1'b0; f_v1 = 1'b0; f_res_ready = 1'b0;
    #12;
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_ovf", res_overflow, 1'b0);
    chk("rst_unf", res_underflow, 1'b0);
    chk("rst_id", res_id, 1'b0);
    chk("rst_dz", res_dz, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    f_v0 = 1'b1; f_v1 = 1'b1; #1;
    chk("fp_r0_a", f_r0, 1'b1);
    chk("fp_r1_a", f_r1, 1'b0);
    @(posedge clk); #1;
    f_v0 = 1'b0; f_v1 = 1'b0;
    n = 0;
    while (!f_res_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("fp_valid", f_res_valid, 1'b1);
    chk("fp_id", f_res_id, 1'b0);
    chk("fp_data", f_res_data, 32'h40400000);
    f_res_ready = 1'b1;
    @(posedge clk); #1;
    f_res_ready = 1'b0;
    f_v0 = 1'b1; f_v1 = 1'b1; #1;
    chk("fp_r0_b", f_r0, 1'b1);
    chk("fp_r1_b", f_r1, 1'b0);
    f_v0 = 1'b0; f_v1 = 1'b0;

    op(1, 1, 32'h40C00000, 32'h40000000, 32'hC0C00000, 32'h40000000, 1'b0, 32'h40400000, 0, 0, 0, 25, 0);
    op(1, 1, 32'h40C00000, 32'h40000000, 32'hC0C00000, 32'h40000000, 1'b1, 32'hC0400000, 0, 0, 0, 25, 0);
    op(1, 1, 32'h40C00000, 32'h40000000, 32'hC0C00000, 32'h40000000, 1'b0, 32'h40400000, 0, 0, 0, 25, 0);
    op(1, 0, 32'h3F800000, 32'h40400000, 32'h0, 32'h0, 1'b0, 32'h3EAAAAAA, 0, 0, 0, 25, 0);
    op(0, 1, 32'h0, 32'h0, 32'h7F000000, 32'h3F000000, 1'b1, 32'h00000000, 1, 0, 0, 25, 0);
    op(1, 0, 32'h00800000, 32'h7F000000, 32'h0, 32'h0, 1'b0, 32'h00000000, 0, 1, 0, 25, 0);
    op(0, 1, 32'h0, 32'h0, 32'hC0C00000, 32'h40000000, 1'b1, 32'hC0400000, 0, 0, 0, 25, 10);

    req0_valid = 1'b1; req0_a = 32'h40C00000; req0_b = 32'h40000000; #1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0; req1_valid = 1'b1; #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_valid", res_valid, 1'b0);
    chk("mid_rdy0", req0_ready, 1'b0);
    chk("mid_rdy1", req1_ready, 1'b0);
    chk("mid_data", res_data, 32'h0);
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(1, 1, 32'h3F800000, 32'h40400000, 32'hC0C00000, 32'h40000000, 1'b0, 32'h3EAAAAAA, 0, 0, 0, 25, 0);

`ifdef FPDIV_SEQ_ZERO_CHK_EN
    op(1, 0, 32'h3F800000, 32'h00000000, 32'h0, 32'h0, 1'b0, 32'h7F800000, 1, 0, 1, 1, 0);
    op(1, 0, 32'h40C00000, 32'h40000000, 32'h0, 32'h0, 1'b0, 32'h40400000, 0, 0, 0, 25, 0);
`else
    op(1, 0, 32'h3F800000, 32'h00000000, 32'h0, 32'h0, 1'b0, 32'h7F000000, 0, 0, 0, 25, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpdiv_seq_arbiter.md
Name: fpdiv_seq_arbiter

Overview:
- Multi-cycle FP32 (IEEE-754 single) divider shared between two requesters.
- Arbitrates between two valid/ready request ports and runs a restoring mantissa division at one quotient bit per cycle.
- Normalises the result, classifies overflow and underflow, and returns the result tagged with the requester ID.
- Sits between the two arithmetic clients and serves as the area-saving sequential alternative to the combinational divider.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = req0 always wins when both are valid.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  32  requester 0 dividend.
- req0_b  in  32  requester 0 divisor.
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready.
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_id  out  1  requester that owns the result.
- res_data  out  32  quotient; 0 on overflow/underflow.
- res_overflow  out  1  exponent overflow.
- res_underflow  out  1  exponent underflow.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0), effective immediately in any state including mid-division:
  - state=IDLE.
  - All outputs 0.
  - Counter, remainder and quotient registers cleared.
  - Round-robin last-grant = 1, so req0 is favoured first.
- States: IDLE -> DIVIDE -> NORM -> DONE -> IDLE.
- IDLE:
  - Exactly one reqN_ready is high, combinationally: the winner among the valid requesters.
  - No ready is driven when neither requester is valid.
  - When both are valid, the winner is the requester not granted last (FIXED_PRIO=0), or req0 (FIXED_PRIO=1).
  - On the handshake edge, latch sign=a[31]^b[31], ea=a[30:23], eb=b[30:23], ma={1,a[22:0]}, mb={1,b[22:0]} and id; set rem={0,ma}, cnt=0; go to DIVIDE.
- DIVIDE: 24 cycles, cnt 0..23, 25-bit remainder.
  - cnt=0: if rem>=mb then q[23]=1 and rem-=mb, else q[23]=0.
  - cnt=k, k=1..23: rem<<=1; then q[23-k]=(rem>=mb); if set, rem-=mb.
  - After cnt=23, go to NORM.
  - Quotient is truncated; no rounding.
- NORM (1 cycle):
  - e (9-bit) = ea + 127 - eb - (q[23]==0 ? 1 : 0), modulo 512.
  - If q[23]==0, q<<=1.
  - Overflow if e==255 or e[8:7]==2'b10 → data=0, ovf=1.
  - Else underflow if e[8:7]==2'b11 → data=0, unf=1.
  - Else data = {sign, e[7:0], q[22:0]}.
  - Go to DONE.
- DONE:
  - res_valid=1; res_* held stable until res_ready=1.
  - On that edge: res_valid=0, last-grant=id, go to IDLE.
  - No new request is accepted in DONE; the earliest next accept is the following cycle.
- Latency: res_valid rises 25 rising edges after the accepting edge. Minimum initiation interval is 27 cycles with res_ready tied high.
- Operand handling:
  - Zero, Inf, NaN and denormal operands get no special handling; the hidden bit is always 1.
  - A result exponent of 0 is emitted as-is.
- Input changes after the handshake have no effect on an operation in flight.

Optional Feature:
- Macro: FPDIV_SEQ_ZERO_CHK_EN.
- Defined:
  - Adds port res_dz (out, 1).
  - In IDLE on accept, if b[30:0]==0, skip DIVIDE/NORM and go directly to DONE with res_data={sign,8'hFF,23'b0}, res_overflow=1, res_dz=1.
  - res_valid rises on the edge after accept.
  - res_dz is 0 for all other results and after reset.
- Not defined:
  - No res_dz port.
  - A zero divisor is processed as 1.0×2^(0-127) through the normal 25-cycle path.

Test Plan:
- req0 a=0x40C00000, b=0x40000000 → after 25 edges res_valid=1, res_data=0x40400000, id=0, ovf=unf=0.
- req1 a=0xC0C00000 (-6.0), b=0x40000000 → res_data=0xC0400000, id=1.
- req0 a=0x3F800000, b=0x40400000 (1/3) → res_data=0x3EAAAAAA (truncation).
- Out-of-range exponents:
  - a=0x7F000000, b=0x3F000000 → res_overflow=1, res_data=0.
  - a=0x00800000, b=0x7F000000 → res_underflow=1, res_data=0.
- Arbitration and backpressure:
  - Both valid from reset → req0 served first, then req1; repeat → req0 again (FIXED_PRIO=0), and req0 twice with FIXED_PRIO=1.
  - Hold res_ready=0 for 10 cycles → res_* stable, both ready low.
- Reset and zero divisor:
  - Assert rst_n=0 at cnt=12 → all outputs 0 immediately; after release, a new req0 completes correctly.
  - With FPDIV_SEQ_ZERO_CHK_EN, b=0x00000000, a=0x3F800000 → res_data=0x7F800000, ovf=1, res_dz=1 one edge after accept.
